// File: rtl/axi4lite_master_bridge_if.sv
// Signal bundle for the AXI4-Lite master bridge: CPU request/response port plus the five AXI4-Lite channels.
// The master modport is the bridge side; the slave modport is the CPU/interconnect environment side.
interface axi4lite_master_bridge_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cpu_req;
    logic                      cpu_we;
    logic [ADDRESS-1:0]        cpu_addr;
    logic [DATA_WIDTH-1:0]     cpu_wdata;
    logic [DATA_WIDTH/8-1:0]   cpu_wstrb;
    logic                      cpu_busy;
    logic                      cpu_done;
    logic                      cpu_err;
    logic [DATA_WIDTH-1:0]     cpu_rdata;

    logic [ADDRESS-1:0]        M_AWADDR;
    logic                      M_AWVALID;
    logic                      M_AWREADY;
    logic [DATA_WIDTH-1:0]     M_WDATA;
    logic [DATA_WIDTH/8-1:0]   M_WSTRB;
    logic                      M_WVALID;
    logic                      M_WREADY;
    logic [1:0]                M_BRESP;
    logic                      M_BVALID;
    logic                      M_BREADY;
    logic [ADDRESS-1:0]        M_ARADDR;
    logic                      M_ARVALID;
    logic                      M_ARREADY;
    logic [DATA_WIDTH-1:0]     M_RDATA;
    logic [1:0]                M_RRESP;
    logic                      M_RVALID;
    logic                      M_RREADY;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_busy, cpu_done, cpu_err, cpu_rdata,
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input  M_BRESP, M_BVALID, output M_BREADY,
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_busy, cpu_done, cpu_err, cpu_rdata,
        input  M_AWADDR, M_AWVALID, output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY,
        input  M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
    );
endinterface

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding CPU-to-AXI4-Lite master bridge: one read or write at a time, one-cycle cpu_done pulse.
// Optional AXI_MASTER_TIMEOUT_EN adds an abort counter that ends a stalled transaction with cpu_err=1.
module axi4lite_master_bridge #(
    parameter int ADDRESS        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi4lite_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t              state_reg;
    logic [ADDRESS-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                bready_reg;
    logic                arvalid_reg;
    logic                rready_reg;
    logic                done_reg;
    logic                err_reg;

    // A channel counts as finished if it already handshook earlier or handshakes this cycle.
    logic aw_ok;
    logic w_ok;
    assign aw_ok = !awvalid_reg || bus.M_AWREADY;
    assign w_ok  = !wvalid_reg  || bus.M_WREADY;

    if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi4lite_master_bridge: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_reg;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            rdata_reg   <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cpu_req) begin
                        addr_reg  <= bus.cpu_addr;
                        wdata_reg <= bus.cpu_wdata;
                        wstrb_reg <= bus.cpu_wstrb;
                        if (bus.cpu_we) begin
                            state_reg   <= WRITE;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.M_AWREADY) awvalid_reg <= 1'b0;
                    if (bus.M_WREADY)  wvalid_reg  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        state_reg  <= WRESP;
                        bready_reg <= 1'b1;
                    end
                end
                WRESP: begin
                    if (bus.M_BVALID) begin
                        state_reg  <= IDLE;
                        bready_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        err_reg    <= bus.M_BRESP[1];
                    end
                end
                RADDR: begin
                    if (bus.M_ARREADY) begin
                        state_reg   <= RDATA;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (bus.M_RVALID) begin
                        state_reg  <= IDLE;
                        rready_reg <= 1'b0;
                        rdata_reg  <= bus.M_RDATA;
                        done_reg   <= 1'b1;
                        err_reg    <= bus.M_RRESP[1];
                    end
                end
                default: state_reg <= IDLE;
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            // Placed after the case so an abort overrides whatever the channel logic scheduled.
            if (state_reg == IDLE) begin
                tmo_cnt_reg <= '0;
            end else if (tmo_cnt_reg == TMO_LAST) begin
                tmo_cnt_reg <= '0;
                state_reg   <= IDLE;
                awvalid_reg <= 1'b0;
                wvalid_reg  <= 1'b0;
                bready_reg  <= 1'b0;
                arvalid_reg <= 1'b0;
                rready_reg  <= 1'b0;
                done_reg    <= 1'b1;
                err_reg     <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
`endif
        end
    end

    assign bus.cpu_busy  = (state_reg != IDLE);
    assign bus.cpu_done  = done_reg;
    assign bus.cpu_err   = err_reg;
    assign bus.cpu_rdata = rdata_reg;
    assign bus.M_AWADDR  = addr_reg;
    assign bus.M_AWVALID = awvalid_reg;
    assign bus.M_WDATA   = wdata_reg;
    assign bus.M_WSTRB   = wstrb_reg;
    assign bus.M_WVALID  = wvalid_reg;
    assign bus.M_BREADY  = bready_reg;
    assign bus.M_ARADDR  = addr_reg;
    assign bus.M_ARVALID = arvalid_reg;
    assign bus.M_RREADY  = rready_reg;
endmodule

// File: doc/axi4lite_master_bridge.md
AXI4LITE_MASTER_BRIDGE -- requirements
Module: axi4lite_master_bridge
Interface
REQ-001 SHALL have parameter ADDRESS, default 32, address width of CPU and AXI sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; WSTRB width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, abort threshold; used only under AXI_MASTER_TIMEOUT_EN.
REQ-004 SHALL have port ACLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port ARESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cpu_req  input  1  request strobe, sampled only in IDLE.
REQ-007 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cpu_addr  input  ADDRESS  byte address.
REQ-009 SHALL have port cpu_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port cpu_wstrb  input  DATA_WIDTH/8  write byte enables.
REQ-011 SHALL have port cpu_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port cpu_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_err  output  1  valid with cpu_done; 1 = SLVERR/DECERR/timeout.
REQ-014 SHALL have port cpu_rdata  output  DATA_WIDTH  last read data, held until next read completes.
REQ-015 SHALL have ports M_AWADDR output ADDRESS, M_AWVALID output 1, M_AWREADY input 1  write address channel.
REQ-016 SHALL have ports M_WDATA output DATA_WIDTH, M_WSTRB output DATA_WIDTH/8, M_WVALID output 1, M_WREADY input 1  write data channel.
REQ-017 SHALL have ports M_BRESP input 2, M_BVALID input 1, M_BREADY output 1  write response channel.
REQ-018 SHALL have ports M_ARADDR output ADDRESS, M_ARVALID output 1, M_ARREADY input 1  read address channel.
REQ-019 SHALL have ports M_RDATA input DATA_WIDTH, M_RRESP input 2, M_RVALID input 1, M_RREADY output 1  read data channel.
Function
REQ-020 SHALL implement FSM states IDLE, WRITE, WRESP, RADDR, RDATA; IDLE->WRITE on cpu_req&cpu_we, IDLE->RADDR on cpu_req&!cpu_we.
REQ-021 SHALL register cpu_addr/cpu_wdata/cpu_wstrb at acceptance; M_* address/data outputs driven from these registers, stable while VALID high.
REQ-022 In WRITE, SHALL assert M_AWVALID and M_WVALID together; each deasserts independently the cycle after its own VALID&READY; WRITE->WRESP once both handshakes done, in either order or same cycle.
REQ-023 In WRESP, SHALL hold M_BREADY=1; on M_BVALID go to IDLE, pulse cpu_done next cycle, cpu_err=M_BRESP[1].
REQ-024 In RADDR, SHALL hold M_ARVALID=1 until M_ARREADY, then RDATA; VALID never withdrawn before handshake.
REQ-025 In RDATA, SHALL hold M_RREADY=1; on M_RVALID capture M_RDATA into cpu_rdata, go to IDLE, pulse cpu_done next cycle, cpu_err=M_RRESP[1].
REQ-026 Minimum latency with always-ready slave SHALL be: req sampled at edge 0, VALIDs high cycle 1, BREADY/RREADY cycle 2, cpu_done cycle 3.
REQ-027 cpu_req while busy SHALL be ignored (no queueing); a new request is accepted in the cycle cpu_done is high.
REQ-028 Write error SHALL leave cpu_rdata unchanged; read error SHALL still capture M_RDATA.
Reset
REQ-029 On ARESET sampled high, SHALL enter IDLE and drive all VALID/READY, cpu_busy, cpu_done, cpu_err, cpu_rdata, captured registers to 0, including mid-transaction.
REQ-030 After reset release, SHALL accept a request on the first edge cpu_req is high.
Configuration
REQ-031 With AXI_MASTER_TIMEOUT_EN defined, a counter cleared in IDLE SHALL count non-IDLE cycles; on reaching TIMEOUT_CYCLES the FSM aborts to IDLE, drops all VALID/READY, pulses cpu_done with cpu_err=1, cpu_rdata unchanged.
REQ-032 Without AXI_MASTER_TIMEOUT_EN, SHALL contain no counter and wait indefinitely for handshakes.
Verification
REQ-033 Write addr 0x10 data 0xDEADBEEF strb 0xF, slave always ready, BRESP=0 -> AW/W cycle 1, cpu_done cycle 3, cpu_err=0.
REQ-034 Write with M_AWREADY delayed 3 cycles after M_WREADY -> M_WVALID drops after its handshake, M_AWVALID held stable, one cpu_done.
REQ-035 Read addr 0x20, RDATA=0x12345678 after 2 wait cycles, RRESP=0 -> cpu_rdata=0x12345678, cpu_err=0; RRESP=2'b10 -> cpu_err=1.
REQ-036 cpu_req pulsed during busy -> ignored; back-to-back request in cpu_done cycle -> accepted.
REQ-037 ARESET high while in WRESP -> all outputs 0 next cycle; with AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8 and M_ARREADY stuck 0 -> cpu_done, cpu_err=1 after 8 busy cycles.
